ex_mem_pipe: RTL and testbench

- Pipeline stage register between execute (ALU) and memory.
- Captures the ALU result plus the instruction's control fields and resolves branches and jumps into a registered PC redirect.
- Squashes wrong-path instructions behind a taken redirect and holds its contents while memory stalls.
- Drives the EX-to-EX forwarding bus and latches HALT into a sticky halted state.

---
 rtl/uarch_pkg.sv | 22 ++
 rtl/redirect_squash_ctl.sv | 50 +++++
 rtl/ex_mem_pipe.sv | 134 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the EX/MEM slice.
package uarch_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

  localparam logic [REG_W-1:0] LINK_REG = 3'd7;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    HALTED
  } xm_state_e;

  typedef struct packed {
    logic             reg_write;
    logic             ld;
    logic             st;
    logic [REG_W-1:0] dest_reg;
  } xm_ctrl_t;

endpackage

// File: rtl/redirect_squash_ctl.sv
// Taken-branch/jump detection, registered PC redirect and wrong-path squash counter.
module redirect_squash_ctl #(
  parameter int unsigned DATA_W        = uarch_pkg::DATA_W,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eff_v,
  input  logic              capture,
  input  logic              branch,
  input  logic              cond,
  input  logic              jmp,
  input  logic [DATA_W-1:0] pc_nxt,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              squash
);

  localparam int unsigned CNT_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

  logic [CNT_W-1:0] squash_cnt;
  logic             taken;

  // A squashed occupant never has eff_v set, so the counter is not reloaded while busy.
  always_comb begin
    taken = eff_v & ((branch & cond) | jmp);
  end

  assign squash = (squash_cnt != '0);

  // Redirect pulse and squash counter advance only on capture cycles; stalls freeze them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      squash_cnt     <= '0;
    end else if (capture) begin
      redirect_valid <= taken;
      if (taken) begin
        redirect_pc <= pc_nxt;
        squash_cnt  <= CNT_W'(SQUASH_CYCLES);
      end else if (squash_cnt != '0) begin
        squash_cnt <= squash_cnt - CNT_W'(1);
      end
    end else begin
      redirect_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with branch redirect, wrong-path squash, stall hold and sticky halt.
module ex_mem_pipe #(
  parameter int unsigned DATA_W        = uarch_pkg::DATA_W,
  parameter int unsigned REG_W         = uarch_pkg::REG_W,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ix_valid_p1,
  input  logic [DATA_W-1:0] alu_output_data,
  input  logic [DATA_W-1:0] pc_nxt_p1,
  input  logic [DATA_W-1:0] nxt_pc_p1,
  input  logic [DATA_W-1:0] rt_p1,
  input  logic [REG_W-1:0]  dest_reg_idix_p1,
  input  logic              reg_write_valid_idix_p1,
  input  logic              ld_idix_p1,
  input  logic              st_idix_p1,
  input  logic              branch_idix_p1,
  input  logic              jmp_idix_p1,
  input  logic              link_idix_p1,
  input  logic              halt_idix_p1,
  input  logic              mem_stall,
  output logic              ix_stall,
  output logic              squash_idix,
  output logic              xm_valid,
  output logic [DATA_W-1:0] xm_alu_data,
  output logic [DATA_W-1:0] xm_store_data,
  output logic [REG_W-1:0]  xm_dest_reg,
  output logic              xm_reg_write,
  output logic              xm_ld,
  output logic              xm_st,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              halted
);

  import uarch_pkg::*;

  xm_state_e state, state_d;
  xm_ctrl_t  ctrl_q, ctrl_d;
  logic      capture;
  logic      eff_v;

  // The instruction held in ID/EX during a stall is still live when the stall
  // releases, so it stays eligible in STALL as well as RUN.
  assign eff_v = ix_valid_p1 & ~squash_idix & (state != HALTED);

  // Next state and capture enable.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) state_d = STALL;
        else           capture = 1'b1;
      end
      STALL: begin
        if (!mem_stall) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (capture && eff_v && halt_idix_p1) state_d = HALTED;
  end

  // Control fields as they will be latched; link and halt override the decoded write enable.
  always_comb begin
    ctrl_d           = '0;
    ctrl_d.reg_write = reg_write_valid_idix_p1 | link_idix_p1;
    ctrl_d.ld        = ld_idix_p1;
    ctrl_d.st        = st_idix_p1;
    ctrl_d.dest_reg  = link_idix_p1 ? LINK_REG : dest_reg_idix_p1;
    if (halt_idix_p1) ctrl_d.reg_write = 1'b0;
    if (!eff_v)       ctrl_d = '0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_d;
  end

  // EX/MEM register: capture, hold under stall, drain to bubbles once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xm_valid      <= 1'b0;
      ctrl_q        <= '0;
      xm_alu_data   <= '0;
      xm_store_data <= '0;
    end else if (state == HALTED) begin
      xm_valid <= 1'b0;
      ctrl_q   <= '0;
    end else if (capture) begin
      xm_valid      <= eff_v;
      ctrl_q        <= ctrl_d;
      xm_alu_data   <= link_idix_p1 ? nxt_pc_p1 : alu_output_data;
      xm_store_data <= rt_p1;
    end
  end

  redirect_squash_ctl #(
    .DATA_W       (DATA_W),
    .SQUASH_CYCLES(SQUASH_CYCLES)
  ) u_redirect_squash_ctl (
    .clk           (clk),
    .rst           (rst),
    .eff_v         (eff_v),
    .capture       (capture),
    .branch        (branch_idix_p1),
    .cond          (alu_output_data[0]),
    .jmp           (jmp_idix_p1),
    .pc_nxt        (pc_nxt_p1),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .squash        (squash_idix)
  );

  assign halted       = (state == HALTED);
  assign ix_stall     = mem_stall | halted;
  assign xm_reg_write = ctrl_q.reg_write;
  assign xm_ld        = ctrl_q.ld;
  assign xm_st        = ctrl_q.st;
  assign xm_dest_reg  = ctrl_q.dest_reg;
  assign fwd_valid    = xm_valid & xm_reg_write & ~xm_ld;
  assign fwd_reg      = xm_dest_reg;
  assign fwd_data     = xm_alu_data;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe.
module tb_ex_mem_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ix_valid_p1 = 1'b0;
  logic [DW-1:0] alu_output_data = '0;
  logic [DW-1:0] pc_nxt_p1 = '0;
  logic [DW-1:0] nxt_pc_p1 = '0;
  logic [DW-1:0] rt_p1 = '0;
  logic [RW-1:0] dest_reg_idix_p1 = '0;
  logic          reg_write_valid_idix_p1 = 1'b0;
  logic          ld_idix_p1 = 1'b0;
  logic          st_idix_p1 = 1'b0;
  logic          branch_idix_p1 = 1'b0;
  logic          jmp_idix_p1 = 1'b0;
  logic          link_idix_p1 = 1'b0;
  logic          halt_idix_p1 = 1'b0;
  logic          mem_stall = 1'b0;

  logic          ix_stall, squash_idix, xm_valid, xm_reg_write, xm_ld, xm_st;
  logic          redirect_valid, fwd_valid, halted;
  logic [DW-1:0] xm_alu_data, xm_store_data, redirect_pc, fwd_data;
  logic [RW-1:0] xm_dest_reg, fwd_reg;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  ex_mem_pipe #(.DATA_W(DW), .REG_W(RW), .SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ix_valid_p1(ix_valid_p1), .alu_output_data(alu_output_data),
    .pc_nxt_p1(pc_nxt_p1), .nxt_pc_p1(nxt_pc_p1), .rt_p1(rt_p1),
    .dest_reg_idix_p1(dest_reg_idix_p1), .reg_write_valid_idix_p1(reg_write_valid_idix_p1),
    .ld_idix_p1(ld_idix_p1), .st_idix_p1(st_idix_p1), .branch_idix_p1(branch_idix_p1),
    .jmp_idix_p1(jmp_idix_p1), .link_idix_p1(link_idix_p1), .halt_idix_p1(halt_idix_p1),
    .mem_stall(mem_stall), .ix_stall(ix_stall), .squash_idix(squash_idix),
    .xm_valid(xm_valid), .xm_alu_data(xm_alu_data), .xm_store_data(xm_store_data),
    .xm_dest_reg(xm_dest_reg), .xm_reg_write(xm_reg_write), .xm_ld(xm_ld), .xm_st(xm_st),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one ID/EX occupant: v alu pcn nxt rt dest rw ld st br jmp link halt
  task automatic op(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] pcn,
                    input logic [DW-1:0] nxt, input logic [DW-1:0] rt, input logic [RW-1:0] dst,
                    input logic rw, input logic ld, input logic st, input logic br,
                    input logic jmp, input logic lnk, input logic hlt);
    ix_valid_p1 = v;  alu_output_data = alu; pc_nxt_p1 = pcn; nxt_pc_p1 = nxt; rt_p1 = rt;
    dest_reg_idix_p1 = dst; reg_write_valid_idix_p1 = rw; ld_idix_p1 = ld; st_idix_p1 = st;
    branch_idix_p1 = br; jmp_idix_p1 = jmp; link_idix_p1 = lnk; halt_idix_p1 = hlt;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_xm_valid", 32'(xm_valid), 32'h0);
    check("rst_redirect", 32'(redirect_valid), 32'h0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_squash", 32'(squash_idix), 32'h0);
    check("rst_ix_stall", 32'(ix_stall), 32'h0);
    rst = 1'b0;

    // Back-to-back ADDs forward
    op(1, 16'h0003, 0, 0, 16'h00AA, 3'd1, 1, 0, 0, 0, 0, 0, 0); step;
    check("add1_data", 32'(xm_alu_data), 32'h3);
    check("add1_fwd", 32'(fwd_valid), 32'h1);
    check("add1_fwd_reg", 32'(fwd_reg), 32'h1);
    check("add1_store", 32'(xm_store_data), 32'hAA);
    op(1, 16'h0005, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0); step;
    check("add2_data", 32'(fwd_data), 32'h5);
    check("add2_fwd", 32'(fwd_valid), 32'h1);

    // BEQZ taken: one-cycle redirect, two killed (second is a would-be jump)
    op(1, 16'h0001, 16'h0040, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0); step;
    check("bt_redirect", 32'(redirect_valid), 32'h1);
    check("bt_redirect_pc", 32'(redirect_pc), 32'h40);
    check("bt_squash", 32'(squash_idix), 32'h1);
    op(1, 16'h0009, 0, 0, 0, 3'd3, 1, 0, 0, 0, 0, 0, 0); step;
    check("bt_pulse_end", 32'(redirect_valid), 32'h0);
    check("bt_kill1_valid", 32'(xm_valid), 32'h0);
    check("bt_kill1_rw", 32'(xm_reg_write), 32'h0);
    check("bt_kill1_fwd", 32'(fwd_valid), 32'h0);
    check("bt_squash2", 32'(squash_idix), 32'h1);
    op(1, 16'h000A, 16'h0090, 16'h0004, 0, 3'd3, 0, 0, 0, 0, 1, 1, 0); step;
    check("bt_kill2_valid", 32'(xm_valid), 32'h0);
    check("bt_kill2_noredir", 32'(redirect_valid), 32'h0);
    check("bt_squash_done", 32'(squash_idix), 32'h0);
    op(1, 16'h000B, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 0, 0); step;
    check("bt_after_valid", 32'(xm_valid), 32'h1);
    check("bt_after_data", 32'(xm_alu_data), 32'hB);

    // BEQZ not taken
    op(1, 16'h0000, 16'h0060, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0); step;
    check("bnt_redirect", 32'(redirect_valid), 32'h0);
    check("bnt_squash", 32'(squash_idix), 32'h0);
    check("bnt_valid", 32'(xm_valid), 32'h1);

    // JAL
    op(1, 16'h0077, 16'h0080, 16'h0012, 0, 3'd2, 0, 0, 0, 0, 1, 1, 0); step;
    check("jal_dest", 32'(xm_dest_reg), 32'h7);
    check("jal_rw", 32'(xm_reg_write), 32'h1);
    check("jal_data", 32'(xm_alu_data), 32'h12);
    check("jal_redirect", 32'(redirect_valid), 32'h1);
    check("jal_redirect_pc", 32'(redirect_pc), 32'h80);
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step;
    check("jal_pulse_end", 32'(redirect_valid), 32'h0);
    step;
    check("jal_squash_done", 32'(squash_idix), 32'h0);

    // LD then three stall cycles, next op captured on release
    op(1, 16'h0100, 0, 0, 0, 3'd4, 1, 1, 0, 0, 0, 0, 0); step;
    check("ld_ld", 32'(xm_ld), 32'h1);
    check("ld_nofwd", 32'(fwd_valid), 32'h0);
    op(1, 16'h0007, 0, 0, 0, 3'd5, 1, 0, 0, 0, 0, 0, 0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("stall_data", 32'(xm_alu_data), 32'h100);
      check("stall_ld", 32'(xm_ld), 32'h1);
      check("stall_dest", 32'(xm_dest_reg), 32'h4);
      check("stall_ix_stall", 32'(ix_stall), 32'h1);
    end
    mem_stall = 1'b0;
    step;
    check("resume_valid", 32'(xm_valid), 32'h1);
    check("resume_data", 32'(xm_alu_data), 32'h7);
    check("resume_ld", 32'(xm_ld), 32'h0);

    // Stall during active squash: counter frozen, exactly two killed
    op(1, 16'h0055, 16'h0200, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 0); step;
    check("js_redirect", 32'(redirect_valid), 32'h1);
    op(1, 16'h0011, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 0, 0);
    mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      check("js_stall_squash", 32'(squash_idix), 32'h1);
      check("js_no_repeat", 32'(redirect_valid), 32'h0);
      check("js_stall_data", 32'(xm_alu_data), 32'h55);
    end
    mem_stall = 1'b0;
    step;
    check("js_kill1", 32'(xm_valid), 32'h0);
    check("js_squash_left", 32'(squash_idix), 32'h1);
    op(1, 16'h0022, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0); step;
    check("js_kill2", 32'(xm_valid), 32'h0);
    check("js_squash_done", 32'(squash_idix), 32'h0);
    op(1, 16'h0033, 0, 0, 0, 3'd3, 1, 0, 1, 0, 0, 0, 0); step;
    check("js_live_valid", 32'(xm_valid), 32'h1);
    check("js_live_data", 32'(xm_alu_data), 32'h33);
    check("js_live_st", 32'(xm_st), 32'h1);

    // HALT: sticky, drains to bubbles, no redirects
    op(1, 16'h0044, 0, 0, 0, 3'd3, 1, 0, 0, 0, 0, 0, 1); step;
    check("halt_valid", 32'(xm_valid), 32'h1);
    check("halt_rw", 32'(xm_reg_write), 32'h0);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_ix_stall", 32'(ix_stall), 32'h1);
    op(1, 16'h0001, 16'h0300, 0, 0, 3'd1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step;
      check("halted_valid", 32'(xm_valid), 32'h0);
      check("halted_sticky", 32'(halted), 32'h1);
      check("halted_noredir", 32'(redirect_valid), 32'h0);
    end
    rst = 1'b1;
    #1;
    check("unhalt_halted", 32'(halted), 32'h0);
    rst = 1'b0;

    // Async reset in the middle of a stall
    op(1, 16'h0300, 0, 0, 0, 3'd6, 1, 1, 0, 0, 0, 0, 0); step;
    check("pre_rst_ld", 32'(xm_ld), 32'h1);
    mem_stall = 1'b1;
    step;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(xm_valid), 32'h0);
    check("arst_ld", 32'(xm_ld), 32'h0);
    check("arst_data", 32'(xm_alu_data), 32'h0);
    check("arst_dest", 32'(xm_dest_reg), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    mem_stall = 1'b0;
    op(1, 16'h0066, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 0, 0); step;
    check("post_rst_valid", 32'(xm_valid), 32'h1);
    check("post_rst_data", 32'(xm_alu_data), 32'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
